// File: rtl/rr_arbiter8_pkg.sv
// ============================================================================
// Module      : rr_arbiter8_pkg
// Description : Shared constants for the 8-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter8_pkg;

    localparam int N_REQ  = 8;
    localparam int PTR_W  = 3;
    localparam int HOLD_W = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter8_pick.sv
// ============================================================================
// Module      : rr_pick8
// Description : Combinational rotating-priority picker, lowest index wins
//               starting from ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             found_o,
    output logic [PTR_W-1:0] idx_o,
    output logic [N_REQ-1:0] onehot_o
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]   w_enc;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign w_dbl = {req_i, req_i} >> ptr_i;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        w_enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = i[PTR_W-1:0];
            end
        end
    end

    assign found_o  = |req_i;
    assign idx_o    = w_enc + ptr_i;
    assign onehot_o = found_o ? (N_REQ'(1) << idx_o) : '0;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-requester round-robin arbiter with registered one-hot grant,
//               release/withdraw/hold-limit exits and a dead cycle per handover.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             release_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             grant_valid_o,
    output logic [PTR_W-1:0] grant_id_o,
    output logic             any_req_o
);

    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    logic [0:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [PTR_W-1:0]  id_q, id_d;

    logic              w_found;
    logic [PTR_W-1:0]  w_idx;
    logic [N_REQ-1:0]  w_onehot;
    logic              w_exit;

    rr_pick8 u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .found_o  (w_found),
        .idx_o    (w_idx),
        .onehot_o (w_onehot)
    );

    assign w_exit = release_i | ~req_i[id_q] | (HOLD_EN && (hold_q == HOLD_LAST));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        valid_d = valid_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d = ST_GRANT;
                    grant_d = w_onehot;
                    valid_d = 1'b1;
                    id_d    = w_idx;
                    hold_d  = '0;
                end
            end
            default: begin
                if (w_exit) begin
                    // Owner moves to lowest priority; grant_id keeps the last owner.
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = id_q + 1'b1;
                end else if (hold_q != {HOLD_W{1'b1}}) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = valid_q;
    assign grant_id_o    = id_q;
    assign any_req_o     = |req_i;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Directed bench for rr_arbiter8 (unlimited and MAX_HOLD=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req_a = 8'h00;
    logic       rel_a = 1'b0;
    logic [7:0] req_b = 8'h00;
    logic       rel_b = 1'b0;

    logic [7:0] grant_a, grant_b;
    logic       valid_a, valid_b;
    logic [2:0] id_a, id_b;
    logic       any_a, any_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(0)) dut_a (
        .clock_i       (clk),
        .reset_i       (rst),
        .req_i         (req_a),
        .release_i     (rel_a),
        .grant_o       (grant_a),
        .grant_valid_o (valid_a),
        .grant_id_o    (id_a),
        .any_req_o     (any_a)
    );

    rr_arbiter8 #(.MAX_HOLD(4)) dut_b (
        .clock_i       (clk),
        .reset_i       (rst),
        .req_i         (req_b),
        .release_i     (rel_b),
        .grant_o       (grant_b),
        .grant_valid_o (valid_b),
        .grant_id_o    (id_b),
        .any_req_o     (any_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_a = 8'hFF;
        rel_a = 1'b0;
        do_reset();
        total++;
        if (grant_a !== 8'h00 || valid_a !== 1'b0 || id_a !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: grant=%h valid=%b id=%0d expected 00/0/0", grant_a, valid_a, id_a);
        end
        total++;
        if (any_a !== 1'b1) begin
            bad++;
            $display("FAIL any_req_ff: got %b expected 1", any_a);
        end
        tick();
        total++;
        if (grant_a !== 8'h01 || valid_a !== 1'b1 || id_a !== 3'd0) begin
            bad++;
            $display("FAIL first_grant: grant=%h valid=%b id=%0d expected 01/1/0", grant_a, valid_a, id_a);
        end
    endtask

    // Owner 0 is granted on entry; releases walk ownership 1..7 then back to 0.
    task automatic test_round_robin();
        logic [7:0] exp_g;
        logic [2:0] exp_id;
        for (int k = 0; k < 8; k++) begin
            rel_a = 1'b1;
            tick();
            rel_a = 1'b0;
            total++;
            if (grant_a !== 8'h00 || valid_a !== 1'b0 || id_a !== 3'(k)) begin
                bad++;
                $display("FAIL rr_idle_%0d: grant=%h valid=%b id=%0d expected 00/0/%0d", k, grant_a, valid_a, id_a, k);
            end
            tick();
            exp_id = 3'((k + 1) % 8);
            exp_g  = 8'h01 << exp_id;
            total++;
            if (grant_a !== exp_g || valid_a !== 1'b1 || id_a !== exp_id) begin
                bad++;
                $display("FAIL rr_grant_%0d: grant=%h id=%0d expected %h/%0d", k, grant_a, id_a, exp_g, exp_id);
            end
        end
    endtask

    task automatic test_wrap_skip();
        for (int k = 0; k < 6; k++) begin
            rel_a = 1'b1;
            tick();
            rel_a = 1'b0;
            tick();
        end
        total++;
        if (grant_a !== 8'h40) begin
            bad++;
            $display("FAIL wrap_owner6: grant=%h expected 40", grant_a);
        end
        rel_a = 1'b1;
        req_a = 8'b0000_0101;
        tick();
        rel_a = 1'b0;
        tick();
        total++;
        if (grant_a !== 8'h01 || id_a !== 3'd0) begin
            bad++;
            $display("FAIL wrap_to0: grant=%h id=%0d expected 01/0", grant_a, id_a);
        end
        rel_a = 1'b1;
        tick();
        rel_a = 1'b0;
        tick();
        total++;
        if (grant_a !== 8'h04 || id_a !== 3'd2) begin
            bad++;
            $display("FAIL skip_to2: grant=%h id=%0d expected 04/2", grant_a, id_a);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] seq [0:10];
        seq = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00,
                8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h10};
        req_a = 8'h00;
        req_b = 8'h30;
        rel_b = 1'b0;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            tick();
            total++;
            if (grant_b !== seq[k]) begin
                bad++;
                $display("FAIL timeout_step_%0d: grant=%h expected %h", k, grant_b, seq[k]);
            end
        end
        req_b = 8'h00;
    endtask

    task automatic test_withdraw();
        req_a = 8'h08;
        do_reset();
        tick();
        total++;
        if (grant_a !== 8'h08 || id_a !== 3'd3) begin
            bad++;
            $display("FAIL withdraw_own: grant=%h id=%0d expected 08/3", grant_a, id_a);
        end
        req_a = 8'h02;
        tick();
        total++;
        if (grant_a !== 8'h00 || valid_a !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_idle: grant=%h valid=%b expected 00/0", grant_a, valid_a);
        end
        tick();
        total++;
        if (grant_a !== 8'h02 || id_a !== 3'd1) begin
            bad++;
            $display("FAIL withdraw_next: grant=%h id=%0d expected 02/1", grant_a, id_a);
        end
        req_a = 8'h00;
        #1;
        total++;
        if (any_a !== 1'b0) begin
            bad++;
            $display("FAIL any_req_zero: got %b expected 0", any_a);
        end
    endtask

    task automatic test_async_reset();
        req_a = 8'h20;
        do_reset();
        tick();
        total++;
        if (grant_a !== 8'h20 || id_a !== 3'd5) begin
            bad++;
            $display("FAIL areset_own: grant=%h id=%0d expected 20/5", grant_a, id_a);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (grant_a !== 8'h00 || valid_a !== 1'b0 || id_a !== 3'd0) begin
            bad++;
            $display("FAIL areset_now: grant=%h valid=%b id=%0d expected 00/0/0", grant_a, valid_a, id_a);
        end
        req_a = 8'h21;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (grant_a !== 8'h01 || id_a !== 3'd0) begin
            bad++;
            $display("FAIL areset_ptr: grant=%h id=%0d expected 01/0", grant_a, id_a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_withdraw();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
